// File: rtl/score_tally.sv
// score_tally: sweeps the 160x120 playfield RAM once per request, counts the
// pixels owned by each of the four players and publishes the counts together
// with the winning player index and a tie flag.
module score_tally #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter int         READ_LATENCY = 1,
    parameter logic [2:0] P1_COLOUR    = 3'b001,
    parameter logic [2:0] P2_COLOUR    = 3'b010,
    parameter logic [2:0] P3_COLOUR    = 3'b100,
    parameter logic [2:0] P4_COLOUR    = 3'b110
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic [14:0] address,
    output logic        ram_req,
    input  logic [2:0]  ram_q,
    output logic        busy,
    output logic        done,
    output logic [14:0] p1_count,
    output logic [14:0] p2_count,
    output logic [14:0] p3_count,
    output logic [14:0] p4_count,
    output logic [1:0]  winner,
    output logic        tie
);

    localparam logic [7:0] X_LAST     = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST     = 7'(HEIGHT - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [7:0]              x_r;
    logic [6:0]              y_r;
    logic                    ram_req_r;
    logic [READ_LATENCY-1:0] vld_r;
    logic [1:0]              drain_r;
    logic [14:0]             cnt_r [4];
    logic                    scan_last_s;
    logic                    start_ok_s;
    logic [14:0]             max_s;
    logic [1:0]              win_s;
    logic [2:0]              eq_s;
    logic                    tie_s;

    // The scan address is the live x/y pair; both sit at zero outside SCAN.
    assign address     = {x_r, y_r};
    assign ram_req     = ram_req_r;
    assign scan_last_s = (x_r == X_LAST) && (y_r == Y_LAST);
    assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_COMPARE: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Address walker: y runs fastest, wraps to zero after the last pixel.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_r <= 8'd0;
            y_r <= 7'd0;
        end else if ((state_r == ST_SCAN) && !scan_last_s) begin
            if (y_r == Y_LAST) begin
                y_r <= 7'd0;
                x_r <= x_r + 8'd1;
            end else begin
                y_r <= y_r + 7'd1;
            end
        end else begin
            x_r <= 8'd0;
            y_r <= 7'd0;
        end
    end

    // Read request is high exactly for the cycles spent in SCAN.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ram_req_r <= 1'b0;
        end else begin
            ram_req_r <= (state_nxt_s == ST_SCAN);
        end
    end

    // Valid pipeline that lines each request up with its RAM data.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vld_r <= '0;
        end else begin
            vld_r <= READ_LATENCY'({vld_r, ram_req_r});
        end
    end

    // DRAIN length counter, one tick per outstanding read slot.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            drain_r <= 2'd0;
        end else if (state_r == ST_DRAIN) begin
            drain_r <= drain_r + 2'd1;
        end else begin
            drain_r <= 2'd0;
        end
    end

    // Working counters: cleared on an accepted start, bumped on owned pixels.
    always_ff @(posedge CLOCK_50) begin
        if (reset || start_ok_s) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 15'd0;
            end
        end else if (vld_r[READ_LATENCY-1]) begin
            case (ram_q)
                P1_COLOUR: cnt_r[0] <= cnt_r[0] + 15'd1;
                P2_COLOUR: cnt_r[1] <= cnt_r[1] + 15'd1;
                P3_COLOUR: cnt_r[2] <= cnt_r[2] + 15'd1;
                P4_COLOUR: cnt_r[3] <= cnt_r[3] + 15'd1;
                default:   cnt_r[0] <= cnt_r[0];
            endcase
        end
    end

    // Winner search: strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        max_s = cnt_r[0];
        win_s = 2'd0;
        eq_s  = 3'd0;
        for (int i = 1; i < 4; i++) begin
            win_s = (cnt_r[i] > max_s) ? 2'(i) : win_s;
            max_s = (cnt_r[i] > max_s) ? cnt_r[i] : max_s;
        end
        for (int i = 0; i < 4; i++) begin
            eq_s = eq_s + ((cnt_r[i] == max_s) ? 3'd1 : 3'd0);
        end
        tie_s = (eq_s >= 3'd2);
    end

    // Published outputs: status flags follow the next state, results load leaving COMPARE.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            p1_count <= 15'd0;
            p2_count <= 15'd0;
            p3_count <= 15'd0;
            p4_count <= 15'd0;
            winner   <= 2'd0;
            tie      <= 1'b0;
        end else begin
            busy <= (state_nxt_s == ST_SCAN) || (state_nxt_s == ST_DRAIN) ||
                    (state_nxt_s == ST_COMPARE);
            done <= (state_nxt_s == ST_DONE);
            if (state_r == ST_COMPARE) begin
                p1_count <= cnt_r[0];
                p2_count <= cnt_r[1];
                p3_count <= cnt_r[2];
                p4_count <= cnt_r[3];
                winner   <= win_s;
                tie      <= tie_s;
            end
        end
    end

endmodule

// File: tb/tb_score_tally.sv
// Directed bench for score_tally: a shared behavioural playfield RAM feeds a
// default instance, a READ_LATENCY=2 instance and a small 16x8 instance.
module tb_score_tally;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic [2:0] mem [0:32767];

    logic        reset1, reset2, reset3;
    logic        start1, start2, start3;
    logic [14:0] address1, address2, address3;
    logic        ram_req1, ram_req2, ram_req3;
    logic [2:0]  q1, q2a, q2, q3;
    logic        busy1, busy2, busy3;
    logic        done1, done2, done3;
    logic [14:0] cnt1 [4];
    logic [14:0] cnt2 [4];
    logic [14:0] cnt3 [4];
    logic [1:0]  win1, win2, win3;
    logic        tie1, tie2, tie3;

    score_tally dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset1), .start(start1), .address(address1),
        .ram_req(ram_req1), .ram_q(q1), .busy(busy1), .done(done1),
        .p1_count(cnt1[0]), .p2_count(cnt1[1]), .p3_count(cnt1[2]), .p4_count(cnt1[3]),
        .winner(win1), .tie(tie1));

    score_tally #(.READ_LATENCY(2)) dut2 (
        .CLOCK_50(CLOCK_50), .reset(reset2), .start(start2), .address(address2),
        .ram_req(ram_req2), .ram_q(q2), .busy(busy2), .done(done2),
        .p1_count(cnt2[0]), .p2_count(cnt2[1]), .p3_count(cnt2[2]), .p4_count(cnt2[3]),
        .winner(win2), .tie(tie2));

    score_tally #(.WIDTH(16), .HEIGHT(8)) dut3 (
        .CLOCK_50(CLOCK_50), .reset(reset3), .start(start3), .address(address3),
        .ram_req(ram_req3), .ram_q(q3), .busy(busy3), .done(done3),
        .p1_count(cnt3[0]), .p2_count(cnt3[1]), .p3_count(cnt3[2]), .p4_count(cnt3[3]),
        .winner(win3), .tie(tie3));

    // RAM models: one and two register stages.
    always @(posedge CLOCK_50) q1 <= mem[address1];
    always @(posedge CLOCK_50) begin
        q2a <= mem[address2];
        q2  <= q2a;
    end
    always @(posedge CLOCK_50) q3 <= mem[address3];

    // Monitors on dut1: done pulses and the full address trace.
    int          done_cnt1 = 0;
    int          addr_bad  = 0;
    int          run_len   = 0;
    int          last_len  = 0;
    logic [14:0] last_addr = 15'd0;
    logic [7:0]  ex = 8'd0;
    logic [6:0]  ey = 7'd0;

    always @(posedge CLOCK_50) begin
        if (!reset1) begin
            if (done1) done_cnt1 <= done_cnt1 + 1;
            if (ram_req1) begin
                if (address1 !== {ex, ey}) addr_bad <= addr_bad + 1;
                run_len   <= run_len + 1;
                last_addr <= address1;
                if (ey == 7'd119) begin
                    ey <= 7'd0;
                    ex <= ex + 8'd1;
                end else begin
                    ey <= ey + 7'd1;
                end
            end else begin
                if (address1 !== 15'd0) addr_bad <= addr_bad + 1;
                if (run_len != 0) last_len <= run_len;
                run_len <= 0;
                ex      <= 8'd0;
                ey      <= 7'd0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1: start1 = v;
            2: start2 = v;
            default: start3 = v;
        endcase
    endtask

    task automatic pulse_start(input int w, output int s);
        @(negedge CLOCK_50);
        set_start(w, 1'b1);
        s = cyc;
        @(negedge CLOCK_50);
        set_start(w, 1'b0);
    endtask

    // Bounded wait for done; records first/last busy cycle seen on the way.
    task automatic wait_done(input int w, input int limit, output int dcyc,
                             output int bfirst, output int blast);
        dcyc = -1; bfirst = -1; blast = -1;
        for (int i = 0; i < limit; i++) begin
            if (get_busy(w)) begin
                if (bfirst < 0) bfirst = cyc;
                blast = cyc;
            end
            if (get_done(w)) begin
                dcyc = cyc;
                break;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic check_res(input int w, input string t, input int e1, input int e2,
                             input int e3, input int e4, input int ew, input int et);
        for (int i = 0; i < 4; i++) begin
            logic [14:0] c;
            int e;
            c = (w == 1) ? cnt1[i] : (w == 2) ? cnt2[i] : cnt3[i];
            e = (i == 0) ? e1 : (i == 1) ? e2 : (i == 2) ? e3 : e4;
            chk($sformatf("%s_p%0d_count", t, i + 1), 32'(c), 32'(e));
        end
        chk({t, "_winner"}, (w == 1) ? 32'(win1) : (w == 2) ? 32'(win2) : 32'(win3), 32'(ew));
        chk({t, "_tie"}, (w == 1) ? 32'(tie1) : (w == 2) ? 32'(tie2) : 32'(tie3), 32'(et));
    endtask

    task automatic check_zero1(input string t);
        chk({t, "_address"}, 32'(address1), 32'd0);
        chk({t, "_ram_req"}, 32'(ram_req1), 32'd0);
        chk({t, "_busy"}, 32'(busy1), 32'd0);
        chk({t, "_done"}, 32'(done1), 32'd0);
        check_res(1, t, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_rect(input int xn, input int yn, input logic [2:0] v);
        for (int x = 0; x < xn; x++)
            for (int y = 0; y < yn; y++)
                mem[{8'(x), 7'(y)}] = v;
    endtask

    initial begin
        int s, s2, d, bf, bl, dc0;
        logic [14:0] av;
        reset1 = 1'b1; reset2 = 1'b1; reset3 = 1'b1;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        // Off-screen addresses hold player-1 paint so a stray read would be counted.
        for (int a = 0; a < 32768; a++) begin
            av = 15'(a);
            mem[a] = ((av[14:7] < 8'd160) && (av[6:0] < 7'd120)) ? 3'b000 : 3'b001;
        end
        repeat (3) @(negedge CLOCK_50);
        check_zero1("reset");
        @(negedge CLOCK_50);
        reset1 = 1'b0; reset2 = 1'b0; reset3 = 1'b0;
        @(negedge CLOCK_50);

        // 1: blank playfield on dut1 and dut2 together.
        @(negedge CLOCK_50);
        start1 = 1'b1; start2 = 1'b1; s = cyc;
        @(negedge CLOCK_50);
        start1 = 1'b0; start2 = 1'b0;
        wait_done(1, 19300, d, bf, bl);
        chk("blank_done_latency", 32'(d - s), 32'd19203);
        chk("blank_busy_first", 32'(bf - s), 32'd1);
        chk("blank_busy_last", 32'(bl - s), 32'd19202);
        chk("blank_busy_at_done", 32'(busy1), 32'd0);
        check_res(1, "blank", 0, 0, 0, 0, 0, 1);
        wait_done(2, 50, d, bf, bl);
        chk("blank_lat2_done_latency", 32'(d - s), 32'd19204);
        check_res(2, "blank_lat2", 0, 0, 0, 0, 0, 1);
        @(negedge CLOCK_50);
        chk("blank_trace_len", 32'(last_len), 32'd19200);
        chk("blank_trace_last", 32'(last_addr), 32'h4FF7);
        chk("blank_trace_order", 32'(addr_bad), 32'd0);

        // 2: 100 x P2 and 50 x P3 plus ignored codes; mid-scan starts ignored.
        for (int y = 0; y < 100; y++) mem[{8'd0, 7'(y)}] = 3'b010;
        for (int y = 70; y < 120; y++) mem[{8'd159, 7'(y)}] = 3'b100;
        mem[{8'd80, 7'd60}] = 3'b111;
        mem[{8'd81, 7'd60}] = 3'b011;
        mem[{8'd82, 7'd60}] = 3'b101;
        mem[{8'd83, 7'd60}] = 3'b111;
        dc0 = done_cnt1;
        @(negedge CLOCK_50);
        start1 = 1'b1; start2 = 1'b1; s = cyc;
        @(negedge CLOCK_50);
        start1 = 1'b0; start2 = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        start1 = 1'b1; start2 = 1'b1;
        @(negedge CLOCK_50);
        start1 = 1'b0; start2 = 1'b0;
        wait_done(1, 19300, d, bf, bl);
        chk("p2p3_done_latency", 32'(d - s), 32'd19203);
        check_res(1, "p2p3", 0, 100, 50, 0, 1, 0);
        wait_done(2, 50, d, bf, bl);
        chk("p2p3_lat2_done_latency", 32'(d - s), 32'd19204);
        check_res(2, "p2p3_lat2", 0, 100, 50, 0, 1, 0);
        repeat (20) @(negedge CLOCK_50);
        chk("p2p3_single_done", 32'(done_cnt1 - dc0), 32'd1);

        // 3: reset at s+5000 aborts, then rows 0..118 of P1 with a timer-bar row.
        fill_rect(160, 119, 3'b001);
        for (int x = 0; x < 160; x++) mem[{8'(x), 7'd119}] = 3'b111;
        pulse_start(1, s);
        while (cyc < s + 2500) @(negedge CLOCK_50);
        chk("hold_busy", 32'(busy1), 32'd1);
        check_res(1, "hold", 0, 100, 50, 0, 1, 0);
        while (cyc < s + 5000) @(negedge CLOCK_50);
        dc0 = done_cnt1;
        reset1 = 1'b1;
        @(negedge CLOCK_50);
        check_zero1("abort");
        reset1 = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        chk("abort_no_done", 32'(done_cnt1 - dc0), 32'd0);
        chk("abort_idle_busy", 32'(busy1), 32'd0);
        pulse_start(1, s);
        wait_done(1, 19300, d, bf, bl);
        chk("rows_done_latency", 32'(d - s), 32'd19203);
        check_res(1, "rows", 19040, 0, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        chk("rows_trace_len", 32'(last_len), 32'd19200);
        chk("rows_trace_last", 32'(last_addr), 32'h4FF7);
        chk("rows_trace_order", 32'(addr_bad), 32'd0);

        // 4: small playfield, P1/P4 tie at 10, poison just outside 16x8.
        fill_rect(17, 9, 3'b001);
        fill_rect(16, 8, 3'b000);
        for (int x = 0; x < 10; x++) begin
            mem[{8'(x), 7'd0}] = 3'b001;
            mem[{8'(x), 7'd7}] = 3'b110;
        end
        pulse_start(3, s);
        wait_done(3, 400, d, bf, bl);
        chk("tie14_done_latency", 32'(d - s), 32'd131);
        chk("tie14_busy_first", 32'(bf - s), 32'd1);
        chk("tie14_busy_last", 32'(bl - s), 32'd130);
        check_res(3, "tie14", 10, 0, 0, 10, 0, 1);

        // 5: start held in DONE restarts straight away; P4 wins with 7.
        start3 = 1'b1; s2 = cyc;
        fill_rect(16, 8, 3'b000);
        for (int y = 0; y < 5; y++) mem[{8'd15, 7'(y)}] = 3'b100;
        for (int x = 0; x < 6; x++) mem[{8'(x), 7'd3}] = 3'b110;
        mem[{8'd15, 7'd7}] = 3'b110;
        for (int x = 8; x < 14; x++) mem[{8'(x), 7'd6}] = 3'b001;
        @(negedge CLOCK_50);
        start3 = 1'b0;
        chk("restart_busy", 32'(busy3), 32'd1);
        chk("restart_ram_req", 32'(ram_req3), 32'd1);
        chk("restart_address", 32'(address3), 32'd0);
        wait_done(3, 400, d, bf, bl);
        chk("p4win_done_latency", 32'(d - s2), 32'd131);
        check_res(3, "p4win", 6, 0, 5, 7, 3, 0);

        // 6: P2 and P3 share the maximum, lower index wins.
        fill_rect(16, 8, 3'b000);
        for (int y = 0; y < 4; y++) begin
            mem[{8'd2, 7'(y)}] = 3'b010;
            mem[{8'd9, 7'(y)}] = 3'b100;
        end
        mem[{8'd5, 7'd5}] = 3'b001;
        pulse_start(3, s);
        wait_done(3, 400, d, bf, bl);
        chk("tie23_done_latency", 32'(d - s), 32'd131);
        check_res(3, "tie23", 1, 4, 4, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
